gtp_loopback_link: RTL and testbench

//  Single-clock model of a serial link endpoint: internal FIFO filled with a counter pattern while we=1.

---
 rtl/gtp_loopback_link.sv | 218 +++++++++++++++++++++
 tb/tb_gtp_loopback_link.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gtp_loopback_link.sv
// Loopback serial link endpoint: counter-pattern FIFO, 10-bit symbol TX, aligning RX with checker.
// Optional UART forwarding of received bytes when UART_TX_EN is defined.
module gtp_loopback_link #(
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter int unsigned LOCK_CNT     = 16,
    parameter int unsigned UNLOCK_CNT   = 4,
    parameter int unsigned CLKS_PER_BIT = 8
) (
    input  logic       write_clk,
    input  logic       reset,
    input  logic       we,
    input  logic       link_ready,
    input  logic       trans_en,
    output logic       gtp_tx_p,
    output logic       gtp_tx_n,
    input  logic       gtp_rx_p,
    input  logic       gtp_rx_n,
    output logic       rxinit_done,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_err,
    output logic       uart_tx
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned GW = $clog2(LOCK_CNT + 1);
    localparam int unsigned BW = $clog2(UNLOCK_CNT + 1);
    localparam logic [9:0] IDLE_SYM = {2'b01, 8'hBC};
    localparam logic [3:0] LAST_BIT = 4'd9;

    typedef enum logic {StHunt, StLocked} rx_state_e;

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr_q, rd_ptr_q;
    logic [7:0]    wr_cnt_q;
    logic          fifo_full, fifo_empty, do_write, do_pop;

    logic [3:0]    tx_cnt_q;
    logic [8:0]    tx_shift_q;
    logic          tx_bit_q;
    logic [9:0]    tx_sym;

    rx_state_e     rx_state_q;
    logic [9:0]    rx_shift_q;
    logic [3:0]    rx_cnt_q;
    logic [GW-1:0] good_q;
    logic [BW-1:0] bad_q;
    logic          rx_done_q, rx_valid_q, rx_err_q;
    logic [7:0]    rx_data_q, rx_exp_q;
    logic          hdr_valid;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_write   = we && !fifo_full;
    assign do_pop     = (tx_cnt_q == 4'd0) && link_ready && !fifo_empty;
    assign tx_sym     = do_pop ? {2'b10, fifo_mem[rd_ptr_q[AW-1:0]]} : IDLE_SYM;

    always_ff @(posedge write_clk) begin
        if (do_write) begin
            fifo_mem[wr_ptr_q[AW-1:0]] <= wr_cnt_q;
        end
    end

    always_ff @(posedge write_clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            if (do_write) begin
                wr_ptr_q <= wr_ptr_q + (AW + 1)'(1);
                wr_cnt_q <= wr_cnt_q + 8'd1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + (AW + 1)'(1);
            end
        end
    end

    // Symbol is loaded at bit count 0 and shifted out MSB first.
    always_ff @(posedge write_clk) begin
        if (reset) begin
            tx_cnt_q   <= '0;
            tx_shift_q <= '0;
            tx_bit_q   <= 1'b1;
        end else begin
            tx_cnt_q <= (tx_cnt_q == LAST_BIT) ? 4'd0 : tx_cnt_q + 4'd1;
            if (tx_cnt_q == 4'd0) begin
                tx_bit_q   <= tx_sym[9];
                tx_shift_q <= tx_sym[8:0];
            end else begin
                tx_bit_q   <= tx_shift_q[8];
                tx_shift_q <= {tx_shift_q[7:0], 1'b0};
            end
        end
    end

    assign gtp_tx_p  = tx_bit_q;
    assign gtp_tx_n  = ~tx_bit_q;
    assign hdr_valid = rx_shift_q[9] ^ rx_shift_q[8];

    always_ff @(posedge write_clk) begin
        if (reset) begin
            rx_state_q <= StHunt;
            rx_shift_q <= '0;
            rx_cnt_q   <= LAST_BIT;
            good_q     <= '0;
            bad_q      <= '0;
            rx_done_q  <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_err_q   <= 1'b0;
            rx_exp_q   <= '0;
        end else begin
            rx_shift_q <= {rx_shift_q[8:0], gtp_rx_p};
            rx_valid_q <= 1'b0;
            if (rx_cnt_q != LAST_BIT) begin
                rx_cnt_q <= rx_cnt_q + 4'd1;
            end else begin
                rx_cnt_q <= 4'd0;
                unique case (rx_state_q)
                    StHunt: begin
                        // Hunt on whole IDLE words: several rotations of the IDLE pattern
                        // carry a legal header and would otherwise lock on the wrong phase.
                        if (rx_shift_q == IDLE_SYM) begin
                            good_q <= good_q + GW'(1);
                            if (good_q == GW'(LOCK_CNT - 1)) begin
                                rx_state_q <= StLocked;
                                rx_done_q  <= 1'b1;
                                bad_q      <= '0;
                            end
                        end else begin
                            good_q   <= '0;
                            rx_cnt_q <= LAST_BIT;
                        end
                    end
                    StLocked: begin
                        if (hdr_valid) begin
                            bad_q <= '0;
                            if (rx_shift_q[9]) begin
                                rx_data_q  <= rx_shift_q[7:0];
                                rx_valid_q <= 1'b1;
                                rx_exp_q   <= rx_shift_q[7:0] + 8'd1;
                                if (rx_shift_q[7:0] != rx_exp_q) begin
                                    rx_err_q <= 1'b1;
                                end
                            end
                        end else if (bad_q == BW'(UNLOCK_CNT - 1)) begin
                            rx_state_q <= StHunt;
                            rx_done_q  <= 1'b0;
                            good_q     <= '0;
                            bad_q      <= '0;
                        end else begin
                            bad_q <= bad_q + BW'(1);
                        end
                    end
                    default: rx_state_q <= StHunt;
                endcase
            end
        end
    end

    assign rxinit_done = rx_done_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign rx_err      = rx_err_q;

    logic unused_rx_n;
    assign unused_rx_n = gtp_rx_n;

`ifdef UART_TX_EN
    localparam int unsigned CW = $clog2(CLKS_PER_BIT + 1);

    logic          uart_busy_q, uart_tx_q;
    logic [8:0]    uart_buf_q;
    logic [3:0]    uart_bits_q;
    logic [CW-1:0] uart_clk_q;

    // Start bit goes out on capture; buffer holds data LSB first followed by the stop bit.
    always_ff @(posedge write_clk) begin
        if (reset) begin
            uart_busy_q <= 1'b0;
            uart_tx_q   <= 1'b1;
            uart_buf_q  <= '1;
            uart_bits_q <= '0;
            uart_clk_q  <= '0;
        end else if (!uart_busy_q) begin
            if (rx_valid_q && trans_en) begin
                uart_busy_q <= 1'b1;
                uart_tx_q   <= 1'b0;
                uart_buf_q  <= {1'b1, rx_data_q};
                uart_bits_q <= '0;
                uart_clk_q  <= '0;
            end
        end else if (uart_clk_q != CW'(CLKS_PER_BIT - 1)) begin
            uart_clk_q <= uart_clk_q + CW'(1);
        end else begin
            uart_clk_q <= '0;
            if (uart_bits_q == 4'd9) begin
                uart_busy_q <= 1'b0;
            end else begin
                uart_tx_q   <= uart_buf_q[0];
                uart_buf_q  <= {1'b1, uart_buf_q[8:1]};
                uart_bits_q <= uart_bits_q + 4'd1;
            end
        end
    end

    assign uart_tx = uart_tx_q;
`else
    localparam int unsigned unused_clks_per_bit = CLKS_PER_BIT;
    logic unused_trans_en;
    assign unused_trans_en = trans_en;
    assign uart_tx = 1'b1;
`endif

endmodule

// File: tb/tb_gtp_loopback_link.sv
// Loopback bench: queue-based model of FIFO/symbol slots feeds a scoreboard checked on rx_valid.
module tb_gtp_loopback_link;

    localparam int unsigned DEPTH     = 16;
    localparam int unsigned LOCK_WAIT = (16 + 10) * 10;

    logic       clk = 1'b0;
    logic       reset, we, link_ready, trans_en, flip;
    logic       tx_p, tx_n, rx_p, rx_n;
    logic       rxinit_done, rx_valid, rx_err, uart_tx;
    logic [7:0] rx_data;

    assign rx_p = tx_p ^ flip;
    assign rx_n = ~rx_p;

    always #5 clk = ~clk;

    gtp_loopback_link #(
        .FIFO_DEPTH  (DEPTH),
        .LOCK_CNT    (16),
        .UNLOCK_CNT  (4),
        .CLKS_PER_BIT(8)
    ) dut (
        .write_clk  (clk),
        .reset      (reset),
        .we         (we),
        .link_ready (link_ready),
        .trans_en   (trans_en),
        .gtp_tx_p   (tx_p),
        .gtp_tx_n   (tx_n),
        .gtp_rx_p   (rx_p),
        .gtp_rx_n   (rx_n),
        .rxinit_done(rxinit_done),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_err     (rx_err),
        .uart_tx    (uart_tx)
    );

    typedef struct {
        logic [7:0] data;
        int         due;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] mq[$];
    logic [7:0] wcnt = 8'd0;
    int         cyc = 0;
    int         slot = 0;
    int         last_pop = -1;
    int         vectors = 0;
    int         miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: a symbol slot opens every 10 clocks after reset; a slot with link_ready and
    // pending data carries the oldest byte, which must emerge 11 clocks later.
    initial begin : model
        bit full;
        forever begin
            @(posedge clk);
            cyc++;
            if (reset) begin
                mq.delete();
                sb.delete();
                wcnt = 8'd0;
                slot = 0;
            end else begin
                full = (mq.size() >= DEPTH);
                if (slot == 0 && link_ready && mq.size() != 0) begin
                    sb.push_back('{data: mq.pop_front(), due: cyc + 11});
                    last_pop = cyc;
                end
                if (we && !full) begin
                    mq.push_back(wcnt);
                    wcnt = wcnt + 8'd1;
                end
                slot = (slot == 9) ? 0 : slot + 1;
            end
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            check("tx_pair", tx_n ^ tx_p, 1);
`ifndef UART_TX_EN
            check("uart_idle", uart_tx, 1);
`endif
            if (!reset && rx_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_rx_valid", rx_data, 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    check("rx_data", rx_data, e.data);
                    check("rx_latency", cyc, e.due);
                end
            end
        end
    end

    task automatic wait_lock(input string name);
        for (int n = 0; n < LOCK_WAIT && !rxinit_done; n++) begin
            @(posedge clk);
            #1;
        end
        check(name, rxinit_done, 1);
    endtask

    task automatic drain();
        we = 1'b0;
        link_ready = 1'b1;
        for (int n = 0; n < 400 && (sb.size() != 0 || mq.size() != 0); n++) begin
            @(posedge clk);
            #1;
        end
        repeat (2) @(posedge clk);
        #1;
        check("drain_pending", sb.size() + mq.size(), 0);
    endtask

    task automatic flip_one();
        exp_t e;
        bit   hit = 1'b0;
        for (int n = 0; n < 40 && !hit; n++) begin
            @(posedge clk);
            #1;
            hit = (last_pop == cyc);
        end
        check("flip_sync", hit, 1);
        if (hit) begin
            // Wire carries bit 6 of the popped byte after the third edge past the load.
            e = sb.pop_back();
            e.data = e.data ^ 8'h40;
            sb.push_back(e);
            repeat (3) @(posedge clk);
            #1 flip = 1'b1;
            @(posedge clk);
            #1 flip = 1'b0;
        end
    endtask

`ifdef UART_TX_EN
    bit uart_done = 1'b0;

    initial begin : uart_chk
        bit         found = 1'b0;
        bit         got = 1'b0;
        logic [9:0] frame;
        frame = {1'b1, 8'hA5, 1'b0};
        for (int i = 0; i < 6000 && !found; i++) begin
            @(posedge clk);
            #2;
            found = !reset && rxinit_done && rx_valid && (rx_data == 8'hA4);
        end
        check("uart_trigger", found, 1);
        if (found) begin
            @(posedge clk);
            #2 trans_en = 1'b1;
            for (int i = 0; i < 20 && !got; i++) begin
                @(posedge clk);
                #2;
                got = rx_valid;
            end
            check("uart_src_valid", got, 1);
            check("uart_src_data", rx_data, 8'hA5);
            @(posedge clk);
            #2 trans_en = 1'b0;
            repeat (4) @(posedge clk);
            #2;
            check("uart_bit", uart_tx, frame[0]);
            for (int k = 1; k < 10; k++) begin
                repeat (8) @(posedge clk);
                #2;
                check("uart_bit", uart_tx, frame[k]);
            end
        end
        uart_done = 1'b1;
    end
`endif

    initial begin : watchdog
        #600000;
        miscompares++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin : stim
        logic [9:0] bits;
        reset = 1'b1;
        we = 1'b0;
        link_ready = 1'b0;
        trans_en = 1'b0;
        flip = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_rxinit_done", rxinit_done, 0);
        check("reset_rx_data", rx_data, 0);
        check("reset_rx_valid", rx_valid, 0);
        check("reset_rx_err", rx_err, 0);
        check("reset_uart_tx", uart_tx, 1);
        check("reset_tx_p", tx_p, 1);
        check("reset_tx_n", tx_n, 0);
        @(negedge clk) reset = 1'b0;

        wait_lock("initial_lock");
        repeat (40) @(negedge clk);

        link_ready = 1'b1;
        we = 1'b1;
        repeat (40) @(negedge clk);
        we = 1'b0;
        @(negedge clk) we = 1'b1;
        repeat (59) @(negedge clk);

        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            we = ($urandom_range(0, 3) != 0);
            link_ready = ($urandom_range(0, 7) != 0);
        end
        drain();
        check("rx_err_clean", rx_err, 0);
        check("lock_held", rxinit_done, 1);

        we = 1'b1;
        repeat (35) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("midreset_rxinit_done", rxinit_done, 0);
        check("midreset_rx_valid", rx_valid, 0);
        @(negedge clk);
        reset = 1'b0;
        we = 1'b0;
        bits = '0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            bits = {bits[8:0], tx_p};
        end
        check("idle_after_reset", bits, 10'h1BC);
        check("unlocked_after_reset", rxinit_done, 0);

        wait_lock("relock");
        we = 1'b1;
        repeat (80) @(negedge clk);
        check("rx_err_after_relock", rx_err, 0);

        flip_one();
        repeat (30) @(negedge clk);
        check("rx_err_set", rx_err, 1);
        check("lock_after_flip", rxinit_done, 1);
        repeat (50) @(negedge clk);
        check("rx_err_sticky", rx_err, 1);

`ifdef UART_TX_EN
        for (int n = 0; n < 5000 && !uart_done; n++) @(negedge clk);
        check("uart_done", uart_done, 1);
`endif
        drain();
        check("final_lock", rxinit_done, 1);
        check("final_rx_err", rx_err, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
